// File: rtl/parity_frame_tx.sv
// Parity-protected serial frame transmitter: start, data LSB-first, parity, stop.
// Optional PARITY_SELF_CHECK_EN flags words whose supplied parity disagrees with the data.
module parity_frame_tx #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  output logic              tx,
  output logic              done,
  output logic              parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              accept;

  assign bit_end = (cnt_q == CNT_LAST);
  assign accept  = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          sh_d    = data_in;
          par_d   = parity_in;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    // Registered pulse lands on the final stop-bit cycle.
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = sh_q[0];
      PARITY:  tx = par_q;
      default: tx = 1'b1;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

`ifdef PARITY_SELF_CHECK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (accept) perr_d = (^data_in) != parity_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed frame-table bench for parity_frame_tx at DATA_W=3, CLKS_PER_BIT=4.
// Honours PARITY_SELF_CHECK_EN when computing the expected parity_err.
module tb_parity_frame_tx;

  logic       clk;
  logic       rst;
  logic [2:0] data_in;
  logic       parity_in;
  logic       start;
  logic       ready;
  logic       busy;
  logic       tx;
  logic       done;
  logic       parity_err;

  int checks;
  int failures;

  parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
    .start(start), .ready(ready), .busy(busy), .tx(tx), .done(done),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // line[k] is the expected tx level during bit slot k (start..stop).
  typedef struct {
    logic [2:0] data;
    logic       par;
    logic       hold;
    int         repulse;
    logic [5:0] line;
    logic       mism;
  } vec_t;

  vec_t vecs[7];

`ifdef PARITY_SELF_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input int n);
    for (int k = 0; k < n; k++) begin
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      step();
    end
  endtask

  task automatic run_frame(input vec_t v);
    data_in   = v.data;
    parity_in = v.par;
    start     = 1'b1;
    step();
    if (!v.hold) start = 1'b0;
    chk("perr_accept", 32'(parity_err), 32'(CHK_EN & v.mism));
    for (int c = 0; c < 24; c++) begin
      chk("frame_tx", 32'(tx), 32'(v.line[c/4]));
      chk("frame_busy", 32'(busy), 32'd1);
      chk("frame_ready", 32'(ready), 32'd0);
      chk("frame_done", 32'(done), 32'(c == 23));
      if (c == v.repulse) begin
        data_in = 3'b111;
        start   = 1'b1;
      end else if (c == v.repulse + 1) begin
        start = 1'b0;
      end
      step();
    end
    chk("gap_tx", 32'(tx), 32'd1);
    chk("gap_ready", 32'(ready), 32'd1);
    chk("gap_done", 32'(done), 32'd0);
    chk("perr_hold", 32'(parity_err), 32'(CHK_EN & v.mism));
    if (!v.hold) begin
      step();
      idle_checks(3);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    data_in   = 3'b000;
    parity_in = 1'b0;

    vecs[0] = '{data: 3'b101, par: 1'b0, hold: 1'b0, repulse: -5,
                line: 6'b101010, mism: 1'b0};
    vecs[1] = '{data: 3'b011, par: 1'b0, hold: 1'b0, repulse: 9,
                line: 6'b100110, mism: 1'b0};
    vecs[2] = '{data: 3'b001, par: 1'b1, hold: 1'b1, repulse: -5,
                line: 6'b110010, mism: 1'b0};
    vecs[3] = '{data: 3'b110, par: 1'b0, hold: 1'b0, repulse: -5,
                line: 6'b101100, mism: 1'b0};
    vecs[4] = '{data: 3'b010, par: 1'b1, hold: 1'b0, repulse: -5,
                line: 6'b110100, mism: 1'b0};
    vecs[5] = '{data: 3'b101, par: 1'b1, hold: 1'b0, repulse: -5,
                line: 6'b111010, mism: 1'b1};
    vecs[6] = '{data: 3'b101, par: 1'b0, hold: 1'b0, repulse: -5,
                line: 6'b101010, mism: 1'b0};

    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    idle_checks(20);

    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        data_in   = 3'b111;
        parity_in = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
          chk("abort_tx", 32'(tx), 32'(c >= 4));
          step();
        end
        rst = 1'b1;
        #1;
        chk("abort_tx_async", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        step();
        step();
        rst = 1'b0;
        idle_checks(2);
      end
      run_frame(vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
